async_fifo: RTL and testbench

- Parameterised FIFO buffer for audio sample words, placed between a sample producer and a sample consumer.
- The block has one clock; reset is asynchronous and active-high.
- "async" in the name refers to the asynchronous reset. Both ports share clk.
- Provides full/empty flow-control flags, a registered read-data output and a fill-level output.

---
 rtl/async_fifo.sv | 51 +++++
 tb/tb_async_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock FIFO for audio sample words with asynchronous active-high reset.
// Flags and fill level are decoded combinationally from the extended (wrap-bit) pointers.
module async_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty,
    output logic [ADDR_WIDTH:0]   level
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
    logic                  wr_acc, rd_acc;

    assign rd_empty = (wr_ptr == rd_ptr);
    assign wr_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign level    = wr_ptr - rd_ptr;

    assign wr_acc = wr_en && !wr_full;
    assign rd_acc = rd_en && !rd_empty;

    // Storage is deliberately unreset; the rst guard keeps writes out while reset is held.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: constant vector table, hand sequences for corner
// cases, and streaming/random phases checked against a queue-based reference model.
module tb_async_fifo;
    localparam int AW    = 3;
    localparam int DW    = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic          wr_full, rd_empty;
    logic [DW-1:0] rd_data;
    logic [AW:0]   level;

    async_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of stored words plus the last word read out.
    int            q[$];
    logic [DW-1:0] m_rd;
    logic          m_rd_acc;

    typedef struct {
        logic          w;
        logic          r;
        logic [DW-1:0] d;
        int            exp_level;
        logic [DW-1:0] exp_rd;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;
    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd = '0;
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic pre_full, pre_empty;
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        pre_full  = (q.size() == DEPTH);
        pre_empty = (q.size() == 0);
        m_rd_acc  = r && !pre_empty;
        if (m_rd_acc) m_rd = DW'(q.pop_front());
        if (w && !pre_full) q.push_back(int'(d));
        #1;
        chk("model_rd_data", 32'(rd_data),  32'(m_rd));
        chk("model_level",   32'(level),    32'(q.size()));
        chk("model_empty",   32'(rd_empty), 32'(q.size() == 0));
        chk("model_full",    32'(wr_full),  32'(q.size() == DEPTH));
    endtask

    initial begin
        int next_wr, rd_cnt, cyc;

        // Fill 1..8, refused 9th write, drain 1..8, refused extra read.
        for (int i = 0; i < 8; i++)
            vt[i] = '{1'b1, 1'b0, DW'(i + 1), i + 1, '0, 1'b0, (i == 7)};
        vt[8] = '{1'b1, 1'b0, DW'(9), 8, '0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++)
            vt[9 + i] = '{1'b0, 1'b1, '0, 7 - i, DW'(i + 1), (i == 7), 1'b0};
        vt[17] = '{1'b0, 1'b1, '0, 0, DW'(8), 1'b1, 1'b0};

        wr_en = 0; rd_en = 0; wr_data = '0;
        rst = 1'b1;
        model_reset();
        #12;
        chk("reset_empty", 32'(rd_empty), 1);
        chk("reset_full",  32'(wr_full),  0);
        chk("reset_level", 32'(level),    0);
        chk("reset_rd",    32'(rd_data),  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            step(vt[i].w, vt[i].d, vt[i].r);
            chk($sformatf("vec%0d_level", i), 32'(level),    32'(vt[i].exp_level));
            chk($sformatf("vec%0d_rd", i),    32'(rd_data),  32'(vt[i].exp_rd));
            chk($sformatf("vec%0d_empty", i), 32'(rd_empty), 32'(vt[i].exp_empty));
            chk($sformatf("vec%0d_full", i),  32'(wr_full),  32'(vt[i].exp_full));
        end

        // Simultaneous read+write at level 4, full, and empty.
        for (int i = 0; i < 4; i++) step(1, DW'('h10 + i), 0);
        step(1, DW'('h55), 1);
        chk("simul4_level", 32'(level),   4);
        chk("simul4_rd",    32'(rd_data), 'h10);
        for (int i = 0; i < 4; i++) step(1, DW'('h20 + i), 0);
        chk("simul_pre_full", 32'(wr_full), 1);
        step(1, DW'('h77), 1);
        chk("simulfull_level", 32'(level),   7);
        chk("simulfull_rd",    32'(rd_data), 'h11);
        for (int i = 0; i < 7; i++) step(0, '0, 1);
        chk("simulfull_dropped", 32'(rd_data), 'h23);
        step(1, DW'('h99), 1);
        chk("simulempty_level", 32'(level),    1);
        chk("simulempty_rd",    32'(rd_data),  'h23);
        chk("simulempty_empty", 32'(rd_empty), 0);
        step(0, '0, 1);
        chk("simulempty_read", 32'(rd_data), 'h99);

        // Write-to-read latency.
        step(1, DW'('hABC), 0);
        chk("lat_empty_after_wr", 32'(rd_empty), 0);
        step(0, '0, 1);
        chk("lat_rd",    32'(rd_data),  'hABC);
        chk("lat_empty", 32'(rd_empty), 1);

        // Asynchronous reset mid-cycle with 5 words stored; enables ignored while held.
        for (int i = 0; i < 5; i++) step(1, DW'('h30 + i), 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_empty", 32'(rd_empty), 1);
        chk("midrst_full",  32'(wr_full),  0);
        chk("midrst_level", 32'(level),    0);
        chk("midrst_rd",    32'(rd_data),  0);
        wr_en = 1; rd_en = 1; wr_data = DW'('h3FF);
        @(posedge clk); #1;
        chk("rsthold_level", 32'(level), 0);
        rst = 1'b0;
        step(0, '0, 1);
        chk("postrst_rd_refused", 32'(rd_data), 0);

        // Streaming across wrap-around: reads only every 5th cycle.
        next_wr = 0; rd_cnt = 0; cyc = 0;
        while (rd_cnt < 100 && cyc < 2000) begin
            logic w, r;
            w = !wr_full && (next_wr < 100);
            r = (cyc % 5 == 0) && !rd_empty;
            step(w, DW'(next_wr), r);
            if (w) next_wr++;
            if (m_rd_acc) begin
                chk("stream_order", 32'(rd_data), 32'(rd_cnt));
                rd_cnt++;
            end
            chk("stream_level_max", 32'(level > (AW+1)'(DEPTH)), 0);
            cyc++;
        end
        chk("stream_done", 32'(rd_cnt), 100);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
